// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and default sizes for mem_bus_bridge
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: memory-side req/ack bus
//   master (bridge): drives req, we, addr, wdata; receives ack, rdata
//   slave  (memory): the reverse
interface mem_bus_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req;
  logic              we;
  logic              ack;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_bridge_watchdog.sv
// bus_watchdog: counts unacknowledged REQ cycles and flags a timeout
//   active  - bridge is in REQ
//   ack     - memory completion this cycle (an ack beats a same-cycle timeout)
//   timeout - abort the access at the end of this cycle
module bus_watchdog #(parameter int TIMEOUT = 255) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic timeout
);
  localparam int CW = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  // Counter rests at zero outside REQ, so it is already cleared on REQ entry
  assign cnt_d   = (active & ~ack) ? cnt_q + CW'(1) : '0;
  assign timeout = active & ~ack & (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: CPU MemRead/MemWrite strobes to a req/ack memory bus with stall
//   clk, reset (async, active-low)
//   cpu_addr/cpu_wdata/cpu_read/cpu_write in; cpu_rdata/cpu_stall/cpu_err out
//   bus: mem_bus_if.master toward memory
//   MEM_BUS_TIMEOUT_EN: abort accesses not acked within TIMEOUT REQ cycles
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  mem_bus_if.master         bus
);
  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              timeout;
`ifdef MEM_BUS_TIMEOUT_EN
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (state_q == REQ),
    .ack    (bus.ack),
    .timeout(timeout)
  );
`else
  assign timeout = TIMEOUT < 0;
`endif
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (cpu_read | cpu_write) begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        we_d    = cpu_write;
        // misaligned word access skips the bus and reports in DONE
        err_d   = |cpu_addr[1:0];
        req_d   = ~err_d;
        state_d = err_d ? DONE : REQ;
      end
      REQ: if (bus.ack) begin
        rdata_d = we_q ? rdata_q : bus.rdata;
        req_d   = 1'b0;
        state_d = DONE;
      end else if (timeout) begin
        req_d   = 1'b0;
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  // stall rises combinationally with the strobe so control holds from the first cycle
  assign cpu_stall = (state_q == REQ) | ((state_q == IDLE) & (cpu_read | cpu_write));
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed and random accesses checked against a transaction-level model
module tb_mem_bus_bridge;
  localparam int TO = 8;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  int          n = 0, fails = 0;
  logic [31:0] exp_rdata = '0;
  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_read (cpu_read),
    .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .cpu_err  (cpu_err),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One CPU access; starts and ends at a negedge. Memory acks in REQ cycle index 'waits'.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rdat);
    bit err, tmo, done;
    int exp_req, c, reqn;
    err = addr[1:0] != 2'b00;
    tmo = !err && TO_EN && waits >= TO;
    exp_req = err ? 0 : tmo ? TO : waits + 1;
    c = 0;
    reqn = 0;
    done = 0;
    cpu_read = rd;
    cpu_write = wr;
    cpu_addr = addr;
    cpu_wdata = wdata;
    bus.ack = 1'b0;
    #1 chk("stall_on_strobe", cpu_stall, 1);
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      bus.ack = 1'b0;
      bus.rdata = $urandom;
      if (bus.req) begin
        chk("req_addr", bus.addr, addr);
        chk("req_we", bus.we, wr);
        chk("req_wdata", bus.wdata, wdata);
        chk("stall_in_req", cpu_stall, 1);
        if (reqn == waits) begin
          bus.ack = 1'b1;
          bus.rdata = rdat;
        end
        reqn++;
      end else if (!cpu_stall) done = 1;
    end
    chk("done_seen", done, 1);
    chk("latency", c, exp_req + 1);
    chk("req_cycles", reqn, exp_req);
    chk("err_pulse", cpu_err, err | tmo);
    if (!err && !tmo && rd && !wr) exp_rdata = rdat;
    chk("rdata", cpu_rdata, exp_rdata);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    bus.ack = 1'b0;
    @(negedge clk);
    chk("idle_req", bus.req, 0);
    chk("idle_err", cpu_err, 0);
    chk("idle_stall", cpu_stall, 0);
    bus.ack = 1'($urandom_range(0, 1));
    bus.rdata = $urandom;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("stray_ack_req", bus.req, 0);
    chk("stray_ack_rdata", cpu_rdata, exp_rdata);
  endtask
  initial begin
    bus.ack = 1'b0;
    bus.rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", bus.req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_err", cpu_err, 0);
    reset = 1'b1;
    @(negedge clk);
    access(1, 0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
    access(0, 1, 32'h0000_0020, 32'h1234_5678, 3, 32'hAAAA_5555);
    access(1, 0, 32'h0000_0006, 32'h0, 0, 32'h1111_1111);
    access(1, 1, 32'h0000_0030, 32'hCAFE_F00D, 1, 32'h2222_2222);
    if (TO_EN) begin
      access(1, 0, 32'h0000_0050, 32'h0, 100, 32'h3333_3333);
      access(1, 0, 32'h0000_0054, 32'h0, TO - 1, 32'h4444_4444);
    end
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0040;
    @(negedge clk);
    chk("mid_req1", bus.req, 1);
    @(negedge clk);
    chk("mid_req2", bus.req, 1);
    reset = 1'b0;
    cpu_read = 1'b0;
    exp_rdata = '0;
    #1;
    chk("mid_rst_req", bus.req, 0);
    chk("mid_rst_stall", cpu_stall, 0);
    chk("mid_rst_rdata", cpu_rdata, exp_rdata);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1, 0, 32'h0000_0044, 32'h0, 2, 32'h5A5A_A5A5);
    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      access(rd, wr, a, $urandom, int'($urandom_range(0, 12)), $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
